qam_demod: RTL and testbench

Receive-side counterpart of the 16-QAM modulator chain. Accepts the 10-bit 3Q6 passband sample stream together with the local carrier (`sin`/`cos` plus phase-zero marker from a `qam_cordic` instance). It correlates each symbol period against both carriers, slices the I/Q integrals to the four amplitude levels, and emits one 4-bit symbol per period on a valid/ready output.

---
 rtl/qam_demod.sv | 166 ++++++++++++++++
 tb/tb_qam_demod.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_demod.sv
// 16-QAM coherent demodulator. Correlates each symbol period of the received
// samples against the local carrier, slices I/Q to four levels, and emits one symbol per period.
module qam_demod #(
    parameter int unsigned SPS    = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned THRESH = 65536
) (
    input  logic       axi_clk,
    input  logic       axi_rstn,
    input  logic       qam_valid,
    input  logic [9:0] qam_in,
    input  logic       cor_valid,
    input  logic       cor_zero,
    input  logic [7:0] sin,
    input  logic [7:0] cos,
    output logic       dout_valid,
    output logic [3:0] dout,
    input  logic       dout_ready,
    output logic       sym_drop,
    output logic       sync_err
);
    localparam int unsigned CNT_W  = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int unsigned PROD_W = 18;
    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(SPS - 1);
    localparam logic signed [ACC_W-1:0] THR_P    = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_N    = -THR_P;

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CNT_W-1:0]           idx;
    logic                       take;
    logic                       first_d, last_d, sync_err_d;
    logic                       accept;

    logic                       s1_vld_q, s1_first_q, s1_last_q;
    logic signed [PROD_W-1:0]   pi_q, pq_q, pi_d, pq_d;
    logic signed [ACC_W-1:0]    acc_i_q, acc_q_q;
    logic                       s2_last_q;
    logic                       dec_vld_q;
    logic [3:0]                 dec_q;
    logic                       dout_valid_q, sym_drop_q, sync_err_q;
    logic [3:0]                 dout_q;

    assign accept = qam_valid && cor_valid;
    assign pi_d   = PROD_W'($signed(qam_in)) * PROD_W'($signed(cos));
    assign pq_d   = PROD_W'($signed(qam_in)) * PROD_W'($signed(sin));

    // Four-level decision, Gray mapped: +3 -> 10, +1 -> 11, -1 -> 01, -3 -> 00
    function automatic logic [1:0] slice(input logic signed [ACC_W-1:0] a);
        logic [1:0] r;
        if (a >= THR_P)          r = 2'b10;
        else if (!a[ACC_W-1])    r = 2'b11;
        else if (a >= THR_N)     r = 2'b01;
        else                     r = 2'b00;
        return r;
    endfunction

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Symbol framing: a phase-zero marker always restarts the symbol at sample 0
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx        = cnt_q;
        take       = 1'b0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        sync_err_d = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (cor_zero) begin
                        state_d = ACC;
                        take    = 1'b1;
                        idx     = '0;
                    end
                end
                ACC: begin
                    take = 1'b1;
                    if (cor_zero) begin
                        idx        = '0;
                        sync_err_d = (cnt_q != '0);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (take) begin
            first_d = (idx == '0);
            last_d  = (idx == LAST_IDX);
            cnt_d   = last_d ? '0 : idx + CNT_W'(1);
        end
    end

    // S1 products, S2 integrate-and-dump, S3 decision
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            pi_q       <= '0;
            pq_q       <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            s2_last_q  <= 1'b0;
            dec_vld_q  <= 1'b0;
            dec_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            s1_vld_q   <= take;
            sync_err_q <= sync_err_d;
            if (take) begin
                s1_first_q <= first_d;
                s1_last_q  <= last_d;
                pi_q       <= pi_d;
                pq_q       <= pq_d;
            end
            if (s1_vld_q) begin
                acc_i_q <= s1_first_q ? ACC_W'(pi_q) : acc_i_q + ACC_W'(pi_q);
                acc_q_q <= s1_first_q ? ACC_W'(pq_q) : acc_q_q + ACC_W'(pq_q);
            end
            s2_last_q <= s1_vld_q && s1_last_q;
            dec_vld_q <= s2_last_q;
            if (s2_last_q) begin
                dec_q <= {slice(acc_i_q), slice(acc_q_q)};
            end
        end
    end

    // One-entry output register; a decision that finds it full and stalled is dropped
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            sym_drop_q   <= 1'b0;
        end else begin
            sym_drop_q <= 1'b0;
            if (dec_vld_q) begin
                if (!dout_valid_q || dout_ready) begin
                    dout_valid_q <= 1'b1;
                    dout_q       <= dec_q;
                end else begin
                    sym_drop_q <= 1'b1;
                end
            end else if (dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign sym_drop   = sym_drop_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_qam_demod.sv
// Self-checking bench for qam_demod: table-driven symbol/slicer vectors, hand-written
// corner sequences, and randomized noisy symbols checked against an integrate-and-slice model.
module tb_qam_demod;
    localparam int SPS    = 16;
    localparam int THRESH = 65536;

    logic       axi_clk, axi_rstn;
    logic       qam_valid, cor_valid, cor_zero, dout_ready;
    logic [9:0] qam_in;
    logic [7:0] sin_c, cos_c;
    logic       dout_valid, sym_drop, sync_err;
    logic [3:0] dout;

    qam_demod #(.SPS(16), .ACC_W(24), .THRESH(65536)) dut (
        .axi_clk    (axi_clk),
        .axi_rstn   (axi_rstn),
        .qam_valid  (qam_valid),
        .qam_in     (qam_in),
        .cor_valid  (cor_valid),
        .cor_zero   (cor_zero),
        .sin        (sin_c),
        .cos        (cos_c),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready),
        .sym_drop   (sym_drop),
        .sync_err   (sync_err)
    );

    typedef struct { logic [3:0] d; int cyc; } exp_t;
    typedef struct { logic [3:0] sym; logic [3:0] exp; } lb_vec_t;
    typedef struct {
        int n_a; int qa; int ca; int sa; int qb; int cb; int sb; logic [3:0] exp;
    } sl_vec_t;

    exp_t    exp_q[$];
    exp_t    mon_e;
    lb_vec_t lb[16];
    sl_vec_t sl[4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drop_cnt = 0;
    int serr_cnt = 0;
    int drop_cyc = -1;
    int serr_cyc = -1;
    int first_acc = 0;
    int last_acc = 0;
    int sq[SPS];
    int sc[SPS];
    int ss[SPS];
    int cos_t[SPS];
    int sin_t[SPS];

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;
    always @(posedge axi_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b10:   return 3;
            2'b11:   return 1;
            2'b01:   return -1;
            default: return -3;
        endcase
    endfunction

    function automatic logic [1:0] decide(input longint a);
        if (a >= THRESH)  return 2'b10;
        if (a >= 0)       return 2'b11;
        if (a >= -THRESH) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: correlate the stored symbol samples against both carriers, then slice
    function automatic logic [3:0] model_sym();
        longint si = 0;
        longint sqs = 0;
        for (int k = 0; k < SPS; k++) begin
            si  += longint'(sq[k]) * longint'(sc[k]);
            sqs += longint'(sq[k]) * longint'(ss[k]);
        end
        return {decide(si), decide(sqs)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        #2;
    endtask

    task automatic fill_ideal(input logic [3:0] sym, input int noise);
        for (int k = 0; k < SPS; k++) begin
            sc[k] = cos_t[k];
            ss[k] = sin_t[k];
            sq[k] = lvl(sym[3:2]) * cos_t[k] + lvl(sym[1:0]) * sin_t[k];
            if (noise > 0) sq[k] += int'($urandom_range(0, 2 * noise)) - noise;
        end
    endtask

    task automatic drive_one(input int q, input int c, input int s, input logic z);
        qam_valid = 1'b1;
        cor_valid = 1'b1;
        qam_in    = 10'(q);
        cos_c     = 8'(c);
        sin_c     = 8'(s);
        cor_zero  = z;
        step();
    endtask

    task automatic idle_cycle();
        qam_valid = 1'b0;
        cor_valid = ($urandom_range(0, 1) == 1);
        cor_zero  = ($urandom_range(0, 1) == 1);
        qam_in    = 10'($urandom);
        step();
    endtask

    task automatic send_samples(input int n, input logic gaps, input logic zero0,
                                input logic push, input logic [3:0] exp, input logic lat);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (gaps) while ($urandom_range(0, 1) == 1) idle_cycle();
            drive_one(sq[k], sc[k], ss[k], (k == 0) && zero0);
            if (k == 0) first_acc = cyc;
        end
        qam_valid = 1'b0;
        cor_zero  = 1'b0;
        last_acc  = cyc;
        if (push) begin
            e.d   = exp;
            e.cyc = lat ? last_acc + 3 : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        repeat (4) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d symbols never appeared, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Output scoreboard and pulse recorder
    always @(negedge axi_clk) begin
        if (axi_rstn) begin
            if (sym_drop) begin
                drop_cnt++;
                drop_cyc = cyc;
            end
            if (sync_err) begin
                serr_cnt++;
                serr_cyc = cyc;
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_symbol: got %0h at cycle %0d, required no output", dout, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dout !== mon_e.d || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                        errors++;
                        $display("FAIL symbol: got %0h at cycle %0d, required %0h at cycle %0d",
                                 dout, cyc, mon_e.d, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] rsym;
        int         serr0;

        for (int k = 0; k < SPS; k++) begin
            cos_t[k] = int'(64.0 * $cos(2.0 * 3.14159265358979 * real'(k) / real'(SPS)));
            sin_t[k] = int'(64.0 * $sin(2.0 * 3.14159265358979 * real'(k) / real'(SPS)));
        end
        for (int i = 0; i < 16; i++) begin
            lb[i].sym = 4'(i);
            lb[i].exp = 4'(i);
        end
        sl[0] = '{16,   64, 64,  0,   0, 0,  0, 4'b1011};
        sl[1] = '{ 8, -128, 64, 64,  -1, 0,  1, 4'b0100};
        sl[2] = '{15,   64, 64,  0,  63, 65, -1, 4'b1101};
        sl[3] = '{ 8, -128, 64, 64,  -1, 1,  0, 4'b0001};

        axi_rstn = 1'b0; qam_valid = 1'b0; cor_valid = 1'b0; cor_zero = 1'b0;
        qam_in = '0; sin_c = '0; cos_c = '0; dout_ready = 1'b1;
        repeat (3) step();
        chk("reset_dout_valid", 32'(dout_valid), 0);
        chk("reset_dout", 32'(dout), 0);
        chk("reset_sym_drop", 32'(sym_drop), 0);
        chk("reset_sync_err", 32'(sync_err), 0);
        axi_rstn = 1'b1;
        repeat (2) step();

        // Ideal loopback of all sixteen symbols back-to-back
        for (int i = 0; i < 16; i++) begin
            fill_ideal(lb[i].sym, 0);
            send_samples(SPS, 1'b0, 1'b1, 1'b1, lb[i].exp, 1'b1);
        end
        wait_drain("loopback");
        chk("loopback_drops", drop_cnt, 0);
        chk("loopback_sync_errs", serr_cnt, 0);

        // Backpressure across two symbols: second decision is dropped
        dout_ready = 1'b0;
        fill_ideal(4'h9, 0);
        send_samples(SPS, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0);
        fill_ideal(4'h6, 0);
        send_samples(SPS, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0);
        repeat (4) step();
        chk("bp_drop_count", drop_cnt, 1);
        chk("bp_drop_cycle", drop_cyc, last_acc + 3);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_valid", 32'(dout_valid), 1);
            chk("bp_hold_data", 32'(dout), 32'h9);
            step();
        end
        dout_ready = 1'b1;
        wait_drain("backpressure");
        chk("bp_valid_after", 32'(dout_valid), 0);
        chk("bp_drop_total", drop_cnt, 1);

        // Phase-zero marker at count 7 restarts the symbol
        serr0 = serr_cnt;
        fill_ideal(4'h5, 0);
        send_samples(7, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0);
        fill_ideal(4'hA, 0);
        send_samples(SPS, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1);
        wait_drain("resync");
        chk("resync_err_count", serr_cnt - serr0, 1);
        chk("resync_err_cycle", serr_cyc, first_acc);
        chk("resync_drops", drop_cnt, 1);

        // Asynchronous reset with a full output register and a half-built symbol
        dout_ready = 1'b0;
        fill_ideal(4'h7, 0);
        send_samples(SPS, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0);
        fill_ideal(4'h2, 0);
        send_samples(9, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0);
        chk("pre_reset_valid", 32'(dout_valid), 1);
        chk("pre_reset_data", 32'(dout), 32'h7);
        #1;
        axi_rstn = 1'b0;
        #1;
        chk("mid_reset_dout_valid", 32'(dout_valid), 0);
        chk("mid_reset_dout", 32'(dout), 0);
        chk("mid_reset_sym_drop", 32'(sym_drop), 0);
        chk("mid_reset_sync_err", 32'(sync_err), 0);
        repeat (2) step();
        dout_ready = 1'b1;
        axi_rstn = 1'b1;
        serr0 = serr_cnt;
        fill_ideal(4'hB, 0);
        for (int k = 3; k < SPS; k++) drive_one(sq[k], sc[k], ss[k], 1'b0);
        qam_valid = 1'b0;
        repeat (5) step();
        chk("post_reset_quiet", 32'(dout_valid), 0);
        fill_ideal(4'hE, 0);
        send_samples(SPS, 1'b0, 1'b1, 1'b1, 4'hE, 1'b1);
        wait_drain("reset_recover");
        chk("post_reset_sync_errs", serr_cnt - serr0, 0);

        // Random input gaps must not change the decisions
        fill_ideal(4'h3, 0);
        send_samples(SPS, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1);
        fill_ideal(4'hC, 0);
        send_samples(SPS, 1'b1, 1'b1, 1'b1, 4'hC, 1'b1);
        wait_drain("gaps");

        // Slicer boundaries driven through crafted sample sets
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < SPS; k++) begin
                if (k < sl[i].n_a) begin
                    sq[k] = sl[i].qa; sc[k] = sl[i].ca; ss[k] = sl[i].sa;
                end else if (k == sl[i].n_a) begin
                    sq[k] = sl[i].qb; sc[k] = sl[i].cb; ss[k] = sl[i].sb;
                end else begin
                    sq[k] = 0; sc[k] = 0; ss[k] = 0;
                end
            end
            send_samples(SPS, 1'b0, 1'b1, 1'b1, sl[i].exp, 1'b1);
        end
        wait_drain("slicer");

        // Noisy random symbols, random gaps, occasionally missing phase-zero marker
        serr0 = serr_cnt;
        for (int i = 0; i < 24; i++) begin
            rsym = 4'($urandom);
            fill_ideal(rsym, 80);
            send_samples(SPS, ($urandom_range(0, 1) == 1),
                         (i == 0) || ($urandom_range(0, 3) != 0), 1'b1, model_sym(), 1'b1);
        end
        wait_drain("random");
        chk("random_drops", drop_cnt, 1);
        chk("random_sync_errs", serr_cnt - serr0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
